// File: rtl/relu_row_buffer_if.sv
// Stream interface for relu_row_buffer: accumulator input handshake on one side,
// fire/row/data burst toward max_pooling on the other.
interface relu_row_buffer_if #(
    parameter int ACC_W  = 16,
    parameter int DATA_W = 6
);
    logic                     in_valid;
    logic signed [ACC_W-1:0]  in_data;
    logic                     in_ready;
    logic                     out_fire;
    logic                     out_row;
    logic [DATA_W-1:0]        out_data;
    logic                     frame_done;

    // block side
    modport slave (
        input  in_valid, in_data,
        output in_ready, out_fire, out_row, out_data, frame_done
    );

    // producer / consumer side
    modport master (
        output in_valid, in_data,
        input  in_ready, out_fire, out_row, out_data, frame_done
    );
endinterface

// File: rtl/relu_row_buffer.sv
// relu_row_buffer: ReLU + shift + saturate each accumulator value, collect an even/odd
// row pair in two banks, then burst the pair out back-to-back for max_pooling.
//
//  state  | meaning
//  IDLE   | waiting for both banks full; out_fire low
//  BURST0 | streaming bank 0 (even row), out_row = 0
//  BURST1 | streaming bank 1 (odd row), out_row = 1
module relu_row_buffer #(
    parameter int ACC_W   = 16,
    parameter int DATA_W  = 6,
    parameter int ROW_LEN = 16,
    parameter int SHIFT   = 4,
    parameter int ROWS    = 16
) (
    input  logic               clk,
    input  logic               rst,
    relu_row_buffer_if.slave   bus
);
    localparam int IDX_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int PAIRS = ROWS / 2;
    localparam int PC_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(ROW_LEN - 1);
    localparam logic [PC_W-1:0]         LAST_PAIR = PC_W'(PAIRS - 1);
    localparam logic signed [ACC_W-1:0] PIX_MAX   = ACC_W'((1 << DATA_W) - 1);

    typedef enum logic [1:0] {IDLE, BURST0, BURST1} state_t;

    state_t             state;
    logic [DATA_W-1:0]  bank0 [ROW_LEN];
    logic [DATA_W-1:0]  bank1 [ROW_LEN];
    logic [1:0]         full;
    logic [1:0]         full_set;
    logic [1:0]         full_clr;
    logic               wr_bank;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic [PC_W-1:0]    pair_cnt;
    logic               accept;
    logic signed [ACC_W-1:0] shifted;
    logic [DATA_W-1:0]  quant;

    logic               fire_q;
    logic               row_q;
    logic [DATA_W-1:0]  data_q;
    logic               done_q;

    assign bus.in_ready   = !full[wr_bank];
    assign accept         = bus.in_valid && !full[wr_bank];
    assign bus.out_fire   = fire_q;
    assign bus.out_row    = row_q;
    assign bus.out_data   = data_q;
    assign bus.frame_done = done_q;

    // ReLU, arithmetic shift and saturation to the output pixel width
    always_comb begin
        shifted = bus.in_data >>> SHIFT;
        quant   = '0;
        if (!bus.in_data[ACC_W-1]) begin
            if (shifted > PIX_MAX) begin
                quant = '1;
            end else begin
                quant = shifted[DATA_W-1:0];
            end
        end
    end

    // Bank full flags: writer sets on the last pixel of a row, reader clears on its last beat.
    // A set and a clear can never target the same bank in one cycle.
    always_comb begin
        full_set = 2'b00;
        full_clr = 2'b00;
        if (accept && (wr_idx == LAST_IDX)) begin
            full_set[wr_bank] = 1'b1;
        end
        if ((state == BURST0) && (rd_idx == LAST_IDX)) begin
            full_clr[0] = 1'b1;
        end
        if ((state == BURST1) && (rd_idx == LAST_IDX)) begin
            full_clr[1] = 1'b1;
        end
    end

    // Write pointer and bank-full bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else begin
            full <= (full | full_set) & ~full_clr;
            if (accept) begin
                if (wr_idx == LAST_IDX) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
        end
    end

    // Pixel storage; contents are meaningless until the matching full flag is set
    always_ff @(posedge clk) begin
        if (accept) begin
            if (wr_bank) begin
                bank1[wr_idx] <= quant;
            end else begin
                bank0[wr_idx] <= quant;
            end
        end
    end

    // Burst sequencer with registered fire/row/data and frame pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_idx   <= '0;
            pair_cnt <= '0;
            fire_q   <= 1'b0;
            row_q    <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (full == 2'b11) begin
                        state  <= BURST0;
                        rd_idx <= '0;
                        fire_q <= 1'b1;
                        row_q  <= 1'b0;
                        data_q <= bank0[0];
                    end
                end
                BURST0: begin
                    if (rd_idx == LAST_IDX) begin
                        state  <= BURST1;
                        rd_idx <= '0;
                        row_q  <= 1'b1;
                        data_q <= bank1[0];
                    end else begin
                        rd_idx <= rd_idx + 1'b1;
                        data_q <= bank0[rd_idx + 1'b1];
                    end
                end
                BURST1: begin
                    if (rd_idx == LAST_IDX) begin
                        state  <= IDLE;
                        rd_idx <= '0;
                        fire_q <= 1'b0;
                        if (pair_cnt == LAST_PAIR) begin
                            pair_cnt <= '0;
                            done_q   <= 1'b1;
                        end else begin
                            pair_cnt <= pair_cnt + 1'b1;
                        end
                    end else begin
                        rd_idx <= rd_idx + 1'b1;
                        data_q <= bank1[rd_idx + 1'b1];
                    end
                end
                default: begin
                    state  <= IDLE;
                    fire_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_relu_row_buffer.sv
// Bench for relu_row_buffer: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based model of the pixel stream.
module tb_relu_row_buffer;
    localparam int ACC_W   = 16;
    localparam int DATA_W  = 6;
    localparam int ROW_LEN = 16;
    localparam int SHIFT   = 4;
    localparam int ROWS    = 16;
    localparam int PAIR    = 2 * ROW_LEN;
    localparam int PAIRS   = ROWS / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    relu_row_buffer_if #(.ACC_W(ACC_W), .DATA_W(DATA_W)) bus ();

    relu_row_buffer #(
        .ACC_W(ACC_W), .DATA_W(DATA_W), .ROW_LEN(ROW_LEN), .SHIFT(SHIFT), .ROWS(ROWS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // model state
    int pix_q[$];
    int pair_q[$];
    int beat, last_fire, acc_cnt, rows_freed, bursts, fd_pending;
    logic prev_fire;
    // observations
    int cap_data[$];
    int cap_row[$];
    int rise_q[$];
    int fd_count, fire_cnt;
    // driver records
    int acc_cyc_q[$];
    int last_acc_cyc;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int quant(input int x);
        int v;
        if (x < 0) return 0;
        v = x / (1 << SHIFT);
        if (v > (1 << DATA_W) - 1) return (1 << DATA_W) - 1;
        return v;
    endfunction

    function automatic int rand_val();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 65535)) - 32768;
            1:       return int'($urandom_range(0, 1100));
            2:       return -int'($urandom_range(1, 600));
            default: return int'($urandom_range(900, 1100));
        endcase
    endfunction

    // Per-cycle model: every accepted value comes out once, in order; each group of
    // PAIR accepts is one burst (first ROW_LEN even, rest odd), starting 2 cycles after
    // the group completes and no earlier than 2 cycles after the previous burst's last beat.
    task automatic monitor_loop();
        logic e_fire;
        int   e_row, e_data;
        forever begin
            @(negedge clk);
            if (rst) begin
                pix_q.delete(); pair_q.delete();
                beat = -1; last_fire = -100; acc_cnt = 0; rows_freed = 0;
                bursts = 0; fd_pending = 0; prev_fire = 1'b0;
                cap_data.delete(); cap_row.delete(); rise_q.delete();
                fd_count = 0; fire_cnt = 0;
            end else begin
                e_fire = 1'b0;
                if (beat >= 0) begin
                    e_fire = 1'b1;
                end else if (pair_q.size() > 0 && cyc >= pair_q[0] + 2 && cyc >= last_fire + 2) begin
                    e_fire = 1'b1;
                    beat = 0;
                    void'(pair_q.pop_front());
                end
                chk("out_fire", int'(bus.out_fire), int'(e_fire));
                chk("frame_done", int'(bus.frame_done), fd_pending);
                fd_pending = 0;
                chk("in_ready", int'(bus.in_ready), int'(((acc_cnt / ROW_LEN) - rows_freed) < 2));
                if (bus.frame_done) fd_count++;
                if (bus.out_fire) begin
                    fire_cnt++;
                    cap_data.push_back(int'(bus.out_data));
                    cap_row.push_back(int'(bus.out_row));
                    if (!prev_fire) rise_q.push_back(cyc);
                end
                prev_fire = bus.out_fire;
                if (e_fire) begin
                    e_row  = (beat >= ROW_LEN) ? 1 : 0;
                    e_data = (pix_q.size() > 0) ? pix_q.pop_front() : -1;
                    if (bus.out_fire) begin
                        chk("out_data", int'(bus.out_data), e_data);
                        chk("out_row", int'(bus.out_row), e_row);
                    end
                    last_fire = cyc;
                    if (beat == ROW_LEN - 1 || beat == PAIR - 1) rows_freed++;
                    beat++;
                    if (beat == PAIR) begin
                        beat = -1;
                        bursts++;
                        if (bursts % PAIRS == 0) fd_pending = 1;
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    pix_q.push_back(quant(int'(bus.in_data)));
                    acc_cnt++;
                    if (acc_cnt % PAIR == 0) pair_q.push_back(cyc);
                end
            end
        end
    endtask

    task automatic send(input int v, input int gap);
        logic got;
        repeat (gap) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        bus.in_data  = ACC_W'(v);
        got = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            got = bus.in_ready;
        end
        if (got) begin
            last_acc_cyc = cyc;
            acc_cyc_q.push_back(cyc);
        end
        chk("send_accepted", int'(got), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_out_fire", int'(bus.out_fire), 0);
        chk("rst_out_row", int'(bus.out_row), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_frame_done", int'(bus.frame_done), 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        acc_cyc_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic wait_fire(output int rise);
        rise = -1;
        for (int n = 0; n < 200 && rise < 0; n++) begin
            @(negedge clk);
            if (bus.out_fire) rise = cyc;
        end
    endtask

    initial begin
        int e2[5];
        int e3[PAIR];
        int base, rise, run;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        fork
            monitor_loop();
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("init_in_ready", int'(bus.in_ready), 1);
        chk("init_out_fire", int'(bus.out_fire), 0);
        @(posedge clk); #1;

        // quantization through a full burst
        e2 = '{0, 1, 63, 63, 63};
        send(-5, 0); send(16, 0); send(1008, 0); send(1024, 0); send(32767, 0);
        for (int i = 5; i < PAIR; i++) send(i * 3, 0);
        repeat (60) @(negedge clk);
        for (int i = 0; i < 5; i++) chk($sformatf("quant_%0d", i), cap_data[i], e2[i]);

        // back-to-back pair with hand-computed burst content
        for (int i = 0; i < ROW_LEN; i++) e3[i] = i + 1;
        for (int i = 0; i < 8; i++) e3[ROW_LEN + i] = 21 + i;
        e3[24] = 9; e3[25] = 10;
        for (int i = 0; i < 6; i++) e3[26 + i] = i + 1;
        @(posedge clk); #1;
        base = cap_data.size();
        for (int i = 0; i < PAIR; i++) send(e3[i] << 4, 0);
        wait_fire(rise);
        chk("pair_latency", rise - last_acc_cyc, 2);
        run = 0;
        while (bus.out_fire && run < 100) begin
            run++;
            @(negedge clk);
        end
        chk("pair_fire_run", run, PAIR);
        for (int i = 0; i < PAIR; i++) begin
            chk($sformatf("pair_data_%0d", i), cap_data[base + i], e3[i]);
            chk($sformatf("pair_row_%0d", i), cap_row[base + i], (i < ROW_LEN) ? 0 : 1);
        end
        @(posedge clk); #1;

        // async reset while outputs hold non-zero values
        chk("pre_rst_out_data", int'(bus.out_data), 6);
        do_reset();

        // continuous in_valid through bursts
        for (int i = 0; i < 3 * PAIR; i++) send(rand_val(), 0);
        repeat (80) @(negedge clk);
        @(posedge clk); #1;
        chk("bp_refill_0", acc_cyc_q[PAIR], rise_q[0] + ROW_LEN);
        chk("bp_refill_1", acc_cyc_q[2 * PAIR], rise_q[1] + ROW_LEN);
        chk("bp_bursts", rise_q.size(), 3);

        // one full frame then one extra pair
        do_reset();
        for (int i = 0; i < PAIRS * PAIR; i++) send(rand_val(), $urandom_range(0, 2));
        repeat (80) @(negedge clk);
        chk("frame_pulses", fd_count, 1);
        chk("frame_bursts", rise_q.size(), PAIRS);
        @(posedge clk); #1;
        for (int i = 0; i < PAIR; i++) send(rand_val(), $urandom_range(0, 1));
        repeat (80) @(negedge clk);
        chk("frame_pulses_after_9", fd_count, 1);
        chk("frame_bursts_9", rise_q.size(), PAIRS + 1);
        @(posedge clk); #1;

        // reset in the middle of the odd row
        for (int i = 0; i < PAIR; i++) send(rand_val(), 0);
        wait_fire(rise);
        chk("mid_rst_rise_seen", int'(rise >= 0), 1);
        repeat (ROW_LEN + 5) @(negedge clk);
        chk("mid_rst_row", int'(bus.out_row), 1);
        chk("mid_rst_fire_before", int'(bus.out_fire), 1);
        do_reset();
        for (int i = 0; i < PAIR - 1; i++) send(rand_val(), 0);
        repeat (40) @(negedge clk);
        chk("mid_rst_no_output", fire_cnt, 0);
        @(posedge clk); #1;
        send(rand_val(), 0);
        wait_fire(rise);
        chk("mid_rst_relatency", rise - last_acc_cyc, 2);
        repeat (60) @(negedge clk);
        @(posedge clk); #1;

        // randomized traffic
        for (int i = 0; i < 5 * PAIR + 10; i++) send(rand_val(), $urandom_range(0, 3));
        repeat (100) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
